// File: rtl/ahb3lite_pkg.sv
// ahb3lite_pkg: AHB3-Lite bus encodings shared by masters and slaves.
package ahb3lite_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HSIZE_DWORD   = 3'b011;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;
    localparam logic       HRESP_ERROR   = 1'b1;
endpackage

// File: rtl/ahb3lite_mem_bist.sv
// ahb3lite_mem_bist: AHB3-Lite master running a four-phase march test
// (W0 up, R0 up, W1 down, R1 down) over a memory window, with sticky status.
module ahb3lite_mem_bist
    import ahb3lite_pkg::*;
#(
    parameter int unsigned HADDR_SIZE = 8,
    parameter int unsigned HDATA_SIZE = 32,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned WORDS      = 64,
    parameter logic [31:0] PATTERN    = 32'hA5C3_5A3C
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fail_o,
    output logic [15:0]           fail_cnt_o,
    output logic [HADDR_SIZE-1:0] fail_addr_o,
    output logic [HDATA_SIZE-1:0] fail_data_o,
    output logic                  HSEL,
    output logic [HADDR_SIZE-1:0] HADDR,
    output logic [HDATA_SIZE-1:0] HWDATA,
    input  logic [HDATA_SIZE-1:0] HRDATA,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    input  logic                  HREADY,
    input  logic                  HRESP
);
    localparam int unsigned AW  = $clog2(WORDS);
    localparam int unsigned BSH = $clog2(HDATA_SIZE / 8);
    localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

    typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, DRAIN, DONE} state_e;

    function automatic logic [HDATA_SIZE-1:0] pattern_of(input logic [AW-1:0] a);
        return {(HDATA_SIZE / 32){PATTERN}} ^ HDATA_SIZE'(a);
    endfunction

    state_e                state_q, state_d;
    logic [AW-1:0]         a_q, a_d;
    logic                  dp_vld_q, dp_vld_d, dp_wr_q, dp_wr_d;
    logic [HADDR_SIZE-1:0] dp_addr_q, dp_addr_d, fail_addr_q, fail_addr_d, addr;
    logic [HDATA_SIZE-1:0] dp_exp_q, dp_exp_d, wdata_q, wdata_d, fail_data_q, fail_data_d, data;
    logic                  fail_q, fail_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  active, wr, start, mism;

    assign active = state_q inside {W0, R0, W1, R1};
    assign wr     = state_q == W0 || state_q == W1;
    assign start  = start_i && (state_q == IDLE || state_q == DONE);
    assign addr   = HADDR_SIZE'(BASE_ADDR) + (HADDR_SIZE'(a_q) << BSH);
    assign data   = (state_q == W1 || state_q == R1) ? ~pattern_of(a_q) : pattern_of(a_q);
    // Judged only when the data phase completes; an error response always counts.
    assign mism   = HREADY && dp_vld_q && (HRESP == HRESP_ERROR || (!dp_wr_q && HRDATA != dp_exp_q));

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        dp_vld_d  = dp_vld_q;
        dp_wr_d   = dp_wr_q;
        dp_addr_d = dp_addr_q;
        dp_exp_d  = dp_exp_q;
        wdata_d   = wdata_q;
        if (start) begin
            state_d = W0;
            a_d     = '0;
        end else if (HREADY) begin
            case (state_q)
                W0:      begin state_d = (a_q == LAST) ? R0 : W0;    a_d = (a_q == LAST) ? '0 : a_q + AW'(1);   end
                R0:      begin state_d = (a_q == LAST) ? W1 : R0;    a_d = (a_q == LAST) ? LAST : a_q + AW'(1); end
                W1:      begin state_d = (a_q == '0) ? R1 : W1;      a_d = (a_q == '0) ? LAST : a_q - AW'(1);   end
                R1:      begin state_d = (a_q == '0) ? DRAIN : R1;   a_d = (a_q == '0) ? '0 : a_q - AW'(1);     end
                DRAIN:   state_d = DONE;
                default: ;
            endcase
        end
        // The accepted address phase becomes the next data phase.
        if (HREADY) begin
            dp_vld_d  = active;
            dp_wr_d   = active && wr;
            dp_addr_d = addr;
            dp_exp_d  = data;
            wdata_d   = (active && wr) ? data : wdata_q;
        end
    end

    always_comb begin
        fail_d      = fail_q;
        cnt_d       = cnt_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        if (start) begin
            fail_d      = 1'b0;
            cnt_d       = '0;
            fail_addr_d = '0;
            fail_data_d = '0;
        end else if (mism) begin
            fail_d      = 1'b1;
            cnt_d       = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
            fail_addr_d = fail_q ? fail_addr_q : dp_addr_q;
            fail_data_d = fail_q ? fail_data_q : HRDATA;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= IDLE;
            a_q         <= '0;
            dp_vld_q    <= 1'b0;
            dp_wr_q     <= 1'b0;
            dp_addr_q   <= '0;
            dp_exp_q    <= '0;
            wdata_q     <= '0;
            fail_q      <= 1'b0;
            cnt_q       <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            dp_vld_q    <= dp_vld_d;
            dp_wr_q     <= dp_wr_d;
            dp_addr_q   <= dp_addr_d;
            dp_exp_q    <= dp_exp_d;
            wdata_q     <= wdata_d;
            fail_q      <= fail_d;
            cnt_q       <= cnt_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign HSEL        = active;
    assign HTRANS      = active ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR       = active ? addr : '0;
    assign HWRITE      = active && wr;
    assign HWDATA      = wdata_q;
    assign HSIZE       = (HDATA_SIZE == 64) ? HSIZE_DWORD : HSIZE_WORD;
    assign HBURST      = HBURST_SINGLE;
    assign HPROT       = HPROT_DATA;
    assign busy_o      = active || state_q == DRAIN;
    assign done_o      = state_q == DONE;
    assign fail_o      = fail_q;
    assign fail_cnt_o  = cnt_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_data_o = fail_data_q;
endmodule

// File: tb/tb_ahb3lite_mem_bist.sv
// tb_ahb3lite_mem_bist: BIST master against a single-port AHB SRAM model with
// optional stuck bit, random wait states and a one-shot error response.
module tb_ahb3lite_mem_bist;
    logic        HCLK = 1'b0, HRESETn = 1'b0, start_i = 1'b0;
    logic        busy_o, done_o, fail_o;
    logic [15:0] fail_cnt_o;
    logic [7:0]  fail_addr_o, HADDR;
    logic [31:0] fail_data_o, HWDATA, HRDATA;
    logic        HSEL, HWRITE, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;

    int errors = 0, checks = 0, stalls = 0;
    logic stall_en = 1'b0, stuck = 1'b0, err_arm = 1'b0, mon_en = 1'b0;

    logic [31:0] mem [64];
    logic        ap_v, ap_w, err_ph, err_used, err_hit;
    logic [5:0]  ap_i;
    logic [1:0]  stall_cnt;

    always #5 HCLK = ~HCLK;

    ahb3lite_mem_bist #(.HADDR_SIZE(8), .HDATA_SIZE(32), .BASE_ADDR(0), .WORDS(64), .PATTERN(32'hA5C3_5A3C)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .fail_o(fail_o), .fail_cnt_o(fail_cnt_o), .fail_addr_o(fail_addr_o), .fail_data_o(fail_data_o),
        .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HREADY(HREADY), .HRESP(HRESP)
    );

    // SRAM slave: word 5 bit 0 can be stuck at 1; one read of word 7 can get a two-cycle ERROR.
    assign err_hit = err_arm && !err_used && ap_v && !ap_w && ap_i == 6'd7 && stall_cnt == 2'd0;
    assign HREADY  = stall_cnt == 2'd0 && !(err_hit && !err_ph);
    assign HRESP   = err_hit;
    assign HRDATA  = (ap_v && !ap_w) ? (mem[ap_i] | {31'b0, stuck && ap_i == 6'd5}) : 32'h0;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ap_v <= 1'b0; ap_w <= 1'b0; ap_i <= '0; stall_cnt <= '0; err_ph <= 1'b0; err_used <= 1'b0;
        end else begin
            if (stall_cnt != 2'd0) stall_cnt <= stall_cnt - 2'd1;
            else if (err_hit && !err_ph) err_ph <= 1'b1;
            else begin
                err_ph <= 1'b0;
                if (err_hit) err_used <= 1'b1;
                if (ap_v && ap_w) mem[ap_i] <= HWDATA;
                ap_v <= HSEL && HTRANS[1];
                ap_w <= HWRITE;
                ap_i <= HADDR[7:2];
                if (stall_en && $urandom_range(0, 3) == 0) stall_cnt <= 2'($urandom_range(1, 3));
            end
            if (!err_arm) err_used <= 1'b0;
        end
    end

    logic        prev_rdy = 1'b1, prev_busy = 1'b0;
    logic [42:0] prev_bus = '0;
    always @(negedge HCLK) begin
        if (mon_en && prev_busy && !prev_rdy) begin
            stalls++;
            checks++;
            if ({HADDR, HWRITE, HTRANS, HWDATA} !== prev_bus) begin
                errors++;
                $display("FAIL stall_hold: bus=%h required=%h", {HADDR, HWRITE, HTRANS, HWDATA}, prev_bus);
            end
        end
        prev_rdy  = HREADY;
        prev_busy = busy_o;
        prev_bus  = {HADDR, HWRITE, HTRANS, HWDATA};
    end

    task automatic run_bist(input int poke_at, output int cyc);
        cyc = 0;
        @(negedge HCLK) start_i = 1'b1;
        @(negedge HCLK) start_i = 1'b0;
        while (!done_o && cyc < 4000) begin
            if (busy_o) cyc++;
            start_i = (cyc == poke_at);
            @(negedge HCLK);
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        repeat (2) @(negedge HCLK);
        checks++;
        if ({busy_o, done_o, fail_o, fail_cnt_o, fail_addr_o, fail_data_o} !== '0) begin
            errors++; $display("FAIL reset_status: got=%h required=0", {busy_o, done_o, fail_o, fail_cnt_o, fail_addr_o, fail_data_o});
        end
        checks++;
        if ({HSEL, HTRANS, HWRITE, HADDR, HWDATA} !== '0) begin
            errors++; $display("FAIL reset_bus: got=%h required=0", {HSEL, HTRANS, HWRITE, HADDR, HWDATA});
        end
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);
        checks++;
        if ({busy_o, done_o, HTRANS} !== '0) begin
            errors++; $display("FAIL idle_after_reset: got=%h required=0", {busy_o, done_o, HTRANS});
        end
    endtask

    task automatic test_first_transfer();
        @(negedge HCLK) start_i = 1'b1;
        @(negedge HCLK) start_i = 1'b0;
        checks++;
        if ({busy_o, HSEL, HTRANS, HWRITE, HADDR, HSIZE, HBURST, HPROT} !== {1'b1, 1'b1, 2'b10, 1'b1, 8'h00, 3'd2, 3'd0, 4'd3}) begin
            errors++; $display("FAIL first_addr_phase: got=%h required=%h", {busy_o, HSEL, HTRANS, HWRITE, HADDR, HSIZE, HBURST, HPROT},
                               {1'b1, 1'b1, 2'b10, 1'b1, 8'h00, 3'd2, 3'd0, 4'd3});
        end
        @(negedge HCLK);
        checks++;
        if ({HADDR, HWDATA} !== {8'h04, 32'hA5C35A3C}) begin
            errors++; $display("FAIL pipelined_wdata: got=%h required=%h", {HADDR, HWDATA}, {8'h04, 32'hA5C35A3C});
        end
        for (int i = 0; i < 400 && !done_o; i++) @(negedge HCLK);
        checks++;
        if (done_o !== 1'b1) begin errors++; $display("FAIL first_done: got=%b required=1", done_o); end
    endtask

    task automatic test_pass();
        int cyc;
        run_bist(-1, cyc);
        checks++;
        if (cyc != 257) begin errors++; $display("FAIL pass_cycles: got=%0d required=257", cyc); end
        checks++;
        if ({done_o, busy_o, fail_o, fail_cnt_o, HTRANS, HSEL} !== {1'b1, 1'b0, 1'b0, 16'd0, 2'b00, 1'b0}) begin
            errors++; $display("FAIL pass_status: got=%h required=%h", {done_o, busy_o, fail_o, fail_cnt_o, HTRANS, HSEL},
                               {1'b1, 1'b0, 1'b0, 16'd0, 2'b00, 1'b0});
        end
        checks++;
        if (mem[3] !== 32'h5A3CA5C0) begin errors++; $display("FAIL mem_word3: got=%h required=5a3ca5c0", mem[3]); end
    endtask

    task automatic test_stuck();
        int cyc;
        stuck = 1'b1;
        run_bist(-1, cyc);
        stuck = 1'b0;
        checks++;
        if ({cyc == 257, done_o, fail_o, fail_cnt_o} !== {1'b1, 1'b1, 1'b1, 16'd1}) begin
            errors++; $display("FAIL stuck_status: cyc=%0d done=%b fail=%b cnt=%0d required cyc=257 done=1 fail=1 cnt=1", cyc, done_o, fail_o, fail_cnt_o);
        end
        checks++;
        if ({fail_addr_o, fail_data_o} !== {8'h14, 32'h5A3CA5C7}) begin
            errors++; $display("FAIL stuck_capture: got=%h required=%h", {fail_addr_o, fail_data_o}, {8'h14, 32'h5A3CA5C7});
        end
    endtask

    task automatic test_stall();
        int cyc;
        stall_en = 1'b1;
        mon_en   = 1'b1;
        run_bist(-1, cyc);
        stall_en = 1'b0;
        mon_en   = 1'b0;
        checks++;
        if ({done_o, fail_o, fail_cnt_o} !== {1'b1, 1'b0, 16'd0}) begin
            errors++; $display("FAIL stall_status: got=%h required=%h", {done_o, fail_o, fail_cnt_o}, {1'b1, 1'b0, 16'd0});
        end
        checks++;
        if (cyc <= 257 || stalls == 0) begin
            errors++; $display("FAIL stall_seen: cycles=%0d stalls=%0d required cycles>257 stalls>0", cyc, stalls);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit hit = 1'b0;
        @(negedge HCLK) start_i = 1'b1;
        @(negedge HCLK) start_i = 1'b0;
        for (int i = 0; i < 600 && !hit; i++) begin
            hit = HTRANS == 2'b10 && !HWRITE && HADDR == 8'd40;
            if (!hit) @(negedge HCLK);
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL mid_reach_r0_w10: got=0 required=1"); end
        HRESETn = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, fail_o, fail_cnt_o, HSEL, HTRANS, HWRITE, HADDR, HWDATA} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: got=%h required=0", {busy_o, done_o, fail_o, fail_cnt_o, HSEL, HTRANS, HWRITE, HADDR, HWDATA});
        end
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        checks++;
        if ({busy_o, HTRANS} !== '0) begin errors++; $display("FAIL mid_stays_idle: got=%h required=0", {busy_o, HTRANS}); end
        run_bist(-1, cyc);
        checks++;
        if ({cyc == 257, done_o, fail_o, fail_cnt_o} !== {1'b1, 1'b1, 1'b0, 16'd0}) begin
            errors++; $display("FAIL mid_rerun: cyc=%0d done=%b fail=%b cnt=%0d required cyc=257 done=1 fail=0 cnt=0", cyc, done_o, fail_o, fail_cnt_o);
        end
    endtask

    task automatic test_restart();
        int cyc;
        stuck = 1'b1;
        run_bist(50, cyc);
        stuck = 1'b0;
        checks++;
        if ({cyc == 257, fail_o, fail_cnt_o} !== {1'b1, 1'b1, 16'd1}) begin
            errors++; $display("FAIL busy_start_ignored: cyc=%0d fail=%b cnt=%0d required cyc=257 fail=1 cnt=1", cyc, fail_o, fail_cnt_o);
        end
        @(negedge HCLK) start_i = 1'b1;
        @(negedge HCLK) start_i = 1'b0;
        checks++;
        if ({busy_o, done_o, fail_o, fail_cnt_o, fail_addr_o, fail_data_o} !== {1'b1, 58'd0}) begin
            errors++; $display("FAIL restart_clear: got=%h required=%h", {busy_o, done_o, fail_o, fail_cnt_o, fail_addr_o, fail_data_o}, {1'b1, 58'd0});
        end
        cyc = 0;
        while (!done_o && cyc < 4000) begin
            if (busy_o) cyc++;
            @(negedge HCLK);
        end
        checks++;
        if ({cyc == 257, done_o, fail_o, fail_cnt_o} !== {1'b1, 1'b1, 1'b0, 16'd0}) begin
            errors++; $display("FAIL restart_pass: cyc=%0d done=%b fail=%b cnt=%0d required cyc=257 done=1 fail=0 cnt=0", cyc, done_o, fail_o, fail_cnt_o);
        end
    endtask

    task automatic test_hresp();
        int cyc;
        err_arm = 1'b1;
        run_bist(-1, cyc);
        err_arm = 1'b0;
        checks++;
        if ({cyc == 258, done_o, fail_o, fail_cnt_o} !== {1'b1, 1'b1, 1'b1, 16'd1}) begin
            errors++; $display("FAIL hresp_status: cyc=%0d done=%b fail=%b cnt=%0d required cyc=258 done=1 fail=1 cnt=1", cyc, done_o, fail_o, fail_cnt_o);
        end
        checks++;
        if ({fail_addr_o, fail_data_o} !== {8'h1C, 32'hA5C35A3B}) begin
            errors++; $display("FAIL hresp_capture: got=%h required=%h", {fail_addr_o, fail_data_o}, {8'h1C, 32'hA5C35A3B});
        end
    endtask

    initial begin
        test_reset();
        test_first_transfer();
        test_pass();
        test_stuck();
        test_stall();
        test_reset_mid();
        test_restart();
        test_hresp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
